tmds_pll_lock_ctrl: RTL and testbench
=====================================

// Module: tmds_pll_lock_ctrl
// PURPOSE
//  Supervisor/sequencer for the TMDS PLL (PLLA, 50 MHz in, serial + pixel clocks out).
//  - Drives the PLL RESET pin.
//  - Qualifies the asynchronous LOCK output.
//  - Holds the video datapath in reset until lock has been stable.
//  - Re-sequences the PLL on a lock timeout, a lock loss or a software restart.
//  Runs on the free-running 50 MHz board clock that also feeds PLL CLKIN.
// PARAMETERS
//  RST_HOLD_CYC     64      cycles pll_rst is held high per reset attempt (>=2)
//  LOCK_TIMEOUT_CYC 500000  max cycles in WAIT_LOCK before retry (10 ms @ 50 MHz)
//  STABLE_CYC       4096    consecutive synced-lock-high cycles required before RUN
//  LOSS_FILT_CYC    8       consecutive synced-lock-low cycles in RUN that count as lock loss
//  FAIL_LIMIT       3       consecutive timeouts that set pll_fail
//  Counter width = $clog2(max of the cycle parameters)+1.
// PORTS
//  clk          in  1  50 MHz free-running clock (PLL CLKIN source)
//  rst          in  1  asynchronous, active-high reset
//  pll_lock     in  1  PLLA LOCK, asynchronous to clk
//  restart_req  in  1  single-cycle pulse: force full PLL re-sequence
//  pll_rst      out 1  to PLLA RESET, active high
//  sys_rst      out 1  active-high reset for pixel/serial domains (consumer re-syncs per domain)
//  pll_ready    out 1  high only in RUN
//  pll_fail     out 1  sticky: FAIL_LIMIT consecutive lock timeouts
//  retry_cnt    out 8  lock-timeout count, saturates at 255
//  relock_cnt   out 8  in-RUN lock-loss count, saturates at 255
// BEHAVIOUR
//  - All outputs are registered.
//    Reset values: pll_rst=1, sys_rst=1, pll_ready=0, pll_fail=0, retry_cnt=0, relock_cnt=0.
//    Reset state: RST_PLL, cycle counter cnt=0.
//  - pll_lock passes through a 2-FF synchronizer (lock_s); all decisions use lock_s.
//    Lock-to-decision latency is 2 cycles.
//  - RST_PLL:
//    - pll_rst=1, sys_rst=1.
//    - cnt counts 0..RST_HOLD_CYC-1, then go to WAIT_LOCK with cnt=0.
//    - pll_rst is high for exactly RST_HOLD_CYC cycles after rst release.
//  - WAIT_LOCK:
//    - pll_rst=0, sys_rst=1.
//    - lock_s=1: go to STABLE, cnt=0.
//    - Else at cnt==LOCK_TIMEOUT_CYC-1: retry_cnt++ (saturating), consecutive-timeout counter++, go to RST_PLL.
//    - When the consecutive-timeout counter reaches FAIL_LIMIT, set pll_fail.
//  - STABLE:
//    - Requires lock_s=1 for STABLE_CYC consecutive cycles.
//    - Any lock_s=0: go back to WAIT_LOCK with cnt=0 (full timeout window restarts). Not a timeout; counters unchanged.
//    - At cnt==STABLE_CYC-1 with lock_s=1: go to RUN.
//  - RUN:
//    - sys_rst=0 and pll_ready=1, both from the first cycle in RUN.
//    - Entering RUN clears the consecutive-timeout counter. pll_fail stays set until rst.
//    - lock_s low for LOSS_FILT_CYC consecutive cycles: relock_cnt++, go to RST_PLL.
//    - A shorter low glitch resets the filter count and is otherwise ignored.
//  - Leaving RUN:
//    - sys_rst=1 and pll_ready=0 on the same edge that enters RST_PLL (registered together with the state).
//  - restart_req:
//    - In WAIT_LOCK, STABLE or RUN: go to RST_PLL next cycle, cnt=0. No counter increments.
//    - In RST_PLL: ignored; the hold is not extended.
//  - Simultaneous events:
//    - restart_req has priority over a timeout or lock-loss in the same cycle; no counters increment.
//    - In STABLE, lock_s falling on the terminal cycle goes to WAIT_LOCK, not RUN.
//  - rst mid-operation: immediate return to reset values.
//    pll_rst asserts asynchronously; sys_rst asserts asynchronously.
// TESTING
//  1. Release rst, pll_lock held 0:
//     - pll_rst high exactly 64 cycles.
//     - After 500000 more cycles retry_cnt=1 and pll_rst re-asserts.
//     - After the 3rd timeout pll_fail=1.
//  2. pll_lock rises 100 cycles after pll_rst falls and stays high:
//     - sys_rst falls and pll_ready rises exactly 2+4096 cycles after the rise (+1 for the state register).
//     - retry_cnt=0.
//  3. In STABLE, drop pll_lock for 1 cycle at stable count 4000:
//     - Returns to WAIT_LOCK; re-lock requires the full 4096 cycles.
//     - No counters change.
//  4. In RUN, pull pll_lock low for 7 cycles: no change.
//     Then pull it low for 8 cycles:
//     - relock_cnt=1, sys_rst=1, pll_ready=0, pll_rst=1 for 64 cycles.
//  5. restart_req in RUN on the same cycle the 8th low lock sample lands:
//     - Enters RST_PLL; relock_cnt unchanged.
//     - restart_req during RST_PLL does not lengthen the 64-cycle pll_rst pulse.
//  6. Assert rst while in RUN:
//     - pll_rst=1 and sys_rst=1 before the next clk edge.
//     - All counters and pll_fail read 0.

Source files
------------

// File: rtl/tmds_pll_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tmds_pll_lock_ctrl
// Supervisor/sequencer for the TMDS PLL (PLLA). It drives the PLL RESET pin,
// qualifies the asynchronous LOCK output, and holds the video datapath in
// reset until lock has been stable. The PLL is re-sequenced on a lock
// timeout, a lock loss in RUN, or a software restart.
// The block runs on the free-running 50 MHz board clock that also feeds
// PLL CLKIN.
//
// Ports
//   i_clk          free-running 50 MHz clock
//   i_rst          asynchronous, active-high reset
//   i_pll_lock     PLLA LOCK, asynchronous to i_clk
//   i_restart_req  single-cycle pulse that forces a full PLL re-sequence
//   o_pll_rst      to PLLA RESET, active high
//   o_sys_rst      active-high reset for the pixel/serial domains
//   o_pll_ready    high only in RUN
//   o_pll_fail     sticky, set after FAIL_LIMIT consecutive lock timeouts
//   o_retry_cnt    lock-timeout count, saturates at 255
//   o_relock_cnt   in-RUN lock-loss count, saturates at 255
// ---------------------------------------------------------------------------
module tmds_pll_lock_ctrl #(
  parameter int unsigned RST_HOLD_CYC     = 64,
  parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
  parameter int unsigned STABLE_CYC       = 4096,
  parameter int unsigned LOSS_FILT_CYC    = 8,
  parameter int unsigned FAIL_LIMIT       = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_lock,
  input  logic       i_restart_req,
  output logic       o_pll_rst,
  output logic       o_sys_rst,
  output logic       o_pll_ready,
  output logic       o_pll_fail,
  output logic [7:0] o_retry_cnt,
  output logic [7:0] o_relock_cnt
);

  localparam int unsigned MAX_AB  = (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ? RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
  localparam int unsigned MAX_ABC = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
  localparam int unsigned MAX_CYC = (MAX_ABC > LOSS_FILT_CYC) ? MAX_ABC : LOSS_FILT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned FC_W    = $clog2(FAIL_LIMIT + 1);

  typedef enum logic [1:0] {
    S_RST_PLL   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [FC_W-1:0]   r_fail_cnt;
  logic [FC_W-1:0]   w_fail_cnt_nxt;
  logic              r_pll_fail;
  logic              w_pll_fail_nxt;
  logic [7:0]        r_retry_cnt;
  logic [7:0]        w_retry_cnt_nxt;
  logic [7:0]        r_relock_cnt;
  logic [7:0]        w_relock_cnt_nxt;
  logic              r_pll_rst;
  logic              r_sys_rst;
  logic              r_pll_ready;
  logic              w_pll_rst_nxt;
  logic              w_sys_rst_nxt;
  logic              w_pll_ready_nxt;
  logic              r_lock_meta;
  logic              r_lock_s;

  // Two-flop synchronizer for the asynchronous LOCK pin
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // State, counters and outputs; reset values double as the async assertion
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_RST_PLL;
      r_cnt        <= '0;
      r_fail_cnt   <= '0;
      r_pll_fail   <= 1'b0;
      r_retry_cnt  <= 8'd0;
      r_relock_cnt <= 8'd0;
      r_pll_rst    <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_pll_ready  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fail_cnt   <= w_fail_cnt_nxt;
      r_pll_fail   <= w_pll_fail_nxt;
      r_retry_cnt  <= w_retry_cnt_nxt;
      r_relock_cnt <= w_relock_cnt_nxt;
      r_pll_rst    <= w_pll_rst_nxt;
      r_sys_rst    <= w_sys_rst_nxt;
      r_pll_ready  <= w_pll_ready_nxt;
    end
  end

  // Next-state logic; restart_req is checked first so it beats timeouts/loss
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt + CNT_W'(1);
    w_fail_cnt_nxt   = r_fail_cnt;
    w_pll_fail_nxt   = r_pll_fail;
    w_retry_cnt_nxt  = r_retry_cnt;
    w_relock_cnt_nxt = r_relock_cnt;

    case (r_state)
      S_RST_PLL: begin
        // restart_req is deliberately ignored so the hold is never extended
        if (r_cnt == CNT_W'(RST_HOLD_CYC - 1)) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end

      S_WAIT_LOCK: begin
        if (i_restart_req) begin
          w_state_nxt = S_RST_PLL;
          w_cnt_nxt   = '0;
        end else if (r_lock_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
          w_state_nxt     = S_RST_PLL;
          w_cnt_nxt       = '0;
          w_retry_cnt_nxt = (r_retry_cnt == 8'hFF) ? r_retry_cnt : r_retry_cnt + 8'd1;
          if (r_fail_cnt != FC_W'(FAIL_LIMIT)) begin
            w_fail_cnt_nxt = r_fail_cnt + FC_W'(1);
          end
          // This timeout brings the streak to FAIL_LIMIT
          if (r_fail_cnt >= FC_W'(FAIL_LIMIT - 1)) begin
            w_pll_fail_nxt = 1'b1;
          end
        end
      end

      S_STABLE: begin
        if (i_restart_req) begin
          w_state_nxt = S_RST_PLL;
          w_cnt_nxt   = '0;
        end else if (!r_lock_s) begin
          // Lock dropout restarts the whole timeout window; not a timeout
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(STABLE_CYC - 1)) begin
          w_state_nxt    = S_RUN;
          w_cnt_nxt      = '0;
          w_fail_cnt_nxt = '0;
        end
      end

      S_RUN: begin
        // In RUN the counter tracks consecutive low lock samples
        if (i_restart_req) begin
          w_state_nxt = S_RST_PLL;
          w_cnt_nxt   = '0;
        end else if (r_lock_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(LOSS_FILT_CYC - 1)) begin
          w_state_nxt      = S_RST_PLL;
          w_cnt_nxt        = '0;
          w_relock_cnt_nxt = (r_relock_cnt == 8'hFF) ? r_relock_cnt : r_relock_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = S_RST_PLL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered alongside the state they decode
  always_comb begin
    w_pll_rst_nxt   = (w_state_nxt == S_RST_PLL);
    w_sys_rst_nxt   = (w_state_nxt != S_RUN);
    w_pll_ready_nxt = (w_state_nxt == S_RUN);
  end

  assign o_pll_rst    = r_pll_rst;
  assign o_sys_rst    = r_sys_rst;
  assign o_pll_ready  = r_pll_ready;
  assign o_pll_fail   = r_pll_fail;
  assign o_retry_cnt  = r_retry_cnt;
  assign o_relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_tmds_pll_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tmds_pll_lock_ctrl
// Self-checking bench for tmds_pll_lock_ctrl with shortened cycle parameters.
// Directed scenarios plus a randomized lock/restart phase; every cycle the
// DUT outputs are compared against a behavioural model of the supervisor.
// ---------------------------------------------------------------------------
module tb_tmds_pll_lock_ctrl;

  localparam int T_HOLD   = 6;
  localparam int T_TO     = 30;
  localparam int T_STABLE = 20;
  localparam int T_LOSS   = 5;
  localparam int T_FAIL   = 3;

  localparam int PH_HOLD = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_QUAL = 2;
  localparam int PH_RUN  = 3;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       restart_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       pll_ready;
  logic       pll_fail;
  logic [7:0] retry_cnt;
  logic [7:0] relock_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_phase;
  int m_age;
  int m_lowrun;
  int m_streak;
  int m_retry;
  int m_relock;
  bit m_fail;
  bit m_lockq[$];

  tmds_pll_lock_ctrl #(
    .RST_HOLD_CYC     (T_HOLD),
    .LOCK_TIMEOUT_CYC (T_TO),
    .STABLE_CYC       (T_STABLE),
    .LOSS_FILT_CYC    (T_LOSS),
    .FAIL_LIMIT       (T_FAIL)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pll_lock    (pll_lock),
    .i_restart_req (restart_req),
    .o_pll_rst     (pll_rst),
    .o_sys_rst     (sys_rst),
    .o_pll_ready   (pll_ready),
    .o_pll_fail    (pll_fail),
    .o_retry_cnt   (retry_cnt),
    .o_relock_cnt  (relock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = PH_HOLD;
    m_age    = 0;
    m_lowrun = 0;
    m_streak = 0;
    m_retry  = 0;
    m_relock = 0;
    m_fail   = 1'b0;
    m_lockq  = {1'b0, 1'b0};
  endtask

  task automatic model_go(input int ph);
    m_phase  = ph;
    m_age    = 0;
    m_lowrun = 0;
  endtask

  // One clock edge of the reference: lock is seen two edges after it is sampled
  task automatic model_edge(input bit lock_in, input bit rr);
    bit ls;
    ls = m_lockq.pop_front();
    m_lockq.push_back(lock_in);
    case (m_phase)
      PH_HOLD: begin
        m_age++;
        if (m_age == T_HOLD) model_go(PH_WAIT);
      end
      PH_WAIT: begin
        if (rr) model_go(PH_HOLD);
        else if (ls) model_go(PH_QUAL);
        else begin
          m_age++;
          if (m_age == T_TO) begin
            m_retry  = (m_retry < 255) ? m_retry + 1 : 255;
            m_streak = m_streak + 1;
            if (m_streak >= T_FAIL) m_fail = 1'b1;
            model_go(PH_HOLD);
          end
        end
      end
      PH_QUAL: begin
        if (rr) model_go(PH_HOLD);
        else if (!ls) model_go(PH_WAIT);
        else begin
          m_age++;
          if (m_age == T_STABLE) begin
            m_streak = 0;
            model_go(PH_RUN);
          end
        end
      end
      default: begin
        if (rr) model_go(PH_HOLD);
        else if (ls) m_lowrun = 0;
        else begin
          m_lowrun++;
          if (m_lowrun == T_LOSS) begin
            m_relock = (m_relock < 255) ? m_relock + 1 : 255;
            model_go(PH_HOLD);
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("pll_rst",    32'(pll_rst),    32'(m_phase == PH_HOLD));
    chk("sys_rst",    32'(sys_rst),    32'(m_phase != PH_RUN));
    chk("pll_ready",  32'(pll_ready),  32'(m_phase == PH_RUN));
    chk("pll_fail",   32'(pll_fail),   32'(m_fail));
    chk("retry_cnt",  32'(retry_cnt),  m_retry);
    chk("relock_cnt", 32'(relock_cnt), m_relock);
  endtask

  // Drive inputs at the falling edge, step DUT and model, compare at next fall
  task automatic cyc(input bit lock_v, input bit rr_v);
    pll_lock    = lock_v;
    restart_req = rr_v;
    @(posedge clk);
    model_edge(lock_v, rr_v);
    @(negedge clk);
    restart_req = 1'b0;
    compare_all();
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    pll_lock    = 1'b0;
    restart_req = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b0;
    compare_all();
  endtask

  task automatic run_until_ready(input string tag);
    int n;
    n = 0;
    while (!pll_ready && n < 500) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    chk(tag, 32'(pll_ready), 32'd1);
  endtask

  initial begin
    int hi;
    int n;
    int run_len;
    bit lv;

    rst         = 1'b1;
    pll_lock    = 1'b0;
    restart_req = 1'b0;

    // Reset values and pll_rst hold length with lock held low
    apply_reset();
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    hi = 0;
    while (pll_rst && hi < 200) begin
      hi++;
      cyc(1'b0, 1'b0);
    end
    chk("hold_len", hi, T_HOLD);

    // Timeouts with no lock: retry count and sticky fail
    repeat (T_TO - 1) cyc(1'b0, 1'b0);
    chk("pre_to1_retry", 32'(retry_cnt), 32'd0);
    chk("pre_to1_prst", 32'(pll_rst), 32'd0);
    cyc(1'b0, 1'b0);
    chk("to1_retry", 32'(retry_cnt), 32'd1);
    chk("to1_prst", 32'(pll_rst), 32'd1);
    repeat (2 * (T_HOLD + T_TO) - 1) cyc(1'b0, 1'b0);
    chk("pre_to3_fail", 32'(pll_fail), 32'd0);
    chk("pre_to3_retry", 32'(retry_cnt), 32'd2);
    cyc(1'b0, 1'b0);
    chk("to3_fail", 32'(pll_fail), 32'd1);
    chk("to3_retry", 32'(retry_cnt), 32'd3);

    // Clean lock: rise to ready latency
    apply_reset();
    repeat (T_HOLD + 10) cyc(1'b0, 1'b0);
    n = 0;
    do begin
      cyc(1'b1, 1'b0);
      n++;
    end while (!pll_ready && n < 500);
    chk("lock_to_ready", n, T_STABLE + 3);
    chk("lock_sys_rst", 32'(sys_rst), 32'd0);
    chk("lock_retry", 32'(retry_cnt), 32'd0);

    // One-cycle dropout late in qualification restarts the full window
    apply_reset();
    repeat (T_HOLD) cyc(1'b0, 1'b0);
    repeat (T_STABLE - 1) cyc(1'b1, 1'b0);
    chk("qual_not_ready", 32'(pll_ready), 32'd0);
    cyc(1'b0, 1'b0);
    n = 0;
    do begin
      cyc(1'b1, 1'b0);
      n++;
    end while (!pll_ready && n < 500);
    chk("glitch_relock", n, T_STABLE + 3);
    chk("glitch_retry", 32'(retry_cnt), 32'd0);
    chk("glitch_relock_cnt", 32'(relock_cnt), 32'd0);

    // Short low in RUN is filtered, full-length low is a lock loss
    repeat (T_LOSS - 1) cyc(1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0);
    chk("short_low_ready", 32'(pll_ready), 32'd1);
    chk("short_low_relock", 32'(relock_cnt), 32'd0);
    repeat (T_LOSS + 2) cyc(1'b0, 1'b0);
    chk("loss_relock", 32'(relock_cnt), 32'd1);
    chk("loss_sys_rst", 32'(sys_rst), 32'd1);
    chk("loss_ready", 32'(pll_ready), 32'd0);
    hi = 0;
    while (pll_rst && hi < 200) begin
      hi++;
      cyc(1'b1, 1'b0);
    end
    chk("loss_hold_len", hi, T_HOLD);

    // restart_req on the cycle the last low sample lands wins; hold not extended
    run_until_ready("ready_before_restart");
    repeat (T_LOSS + 1) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("rr_prst", 32'(pll_rst), 32'd1);
    chk("rr_relock", 32'(relock_cnt), 32'd1);
    hi = 1;
    while (pll_rst && hi < 200) begin
      cyc(1'b1, (hi == 2) || (hi == 4));
      if (pll_rst) hi++;
    end
    chk("rr_hold_len", hi, T_HOLD);

    // Asynchronous reset while in RUN
    run_until_ready("ready_before_arst");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_prst", 32'(pll_rst), 32'd1);
    chk("arst_srst", 32'(sys_rst), 32'd1);
    chk("arst_ready", 32'(pll_ready), 32'd0);
    chk("arst_relock", 32'(relock_cnt), 32'd0);
    chk("arst_retry", 32'(retry_cnt), 32'd0);
    chk("arst_fail", 32'(pll_fail), 32'd0);
    @(negedge clk);
    apply_reset();

    // Retry counter saturation
    repeat (260 * (T_HOLD + T_TO)) cyc(1'b0, 1'b0);
    chk("retry_sat", 32'(retry_cnt), 32'd255);

    // Randomized lock activity with occasional restarts
    apply_reset();
    lv = 1'b0;
    run_len = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_len == 0) begin
        lv = ~lv;
        case ($urandom_range(0, 3))
          0:       run_len = $urandom_range(1, T_LOSS + 1);
          1:       run_len = $urandom_range(T_LOSS - 1, T_LOSS + 3);
          2:       run_len = $urandom_range(T_STABLE - 2, T_STABLE + 6);
          default: run_len = $urandom_range(1, 2 * T_TO);
        endcase
      end
      run_len--;
      cyc(lv, ($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
